input_fmap_buffer: RTL and testbench

Double-buffered, multi-channel input feature-map buffer between the AXI write path and the data-preprocessing unit. It unpacks `PACK` elements of `DATA_W` bits from each 32-bit write word and assembles complete `CHANNELS × IN_H × IN_W` maps in two ping-pong banks. Each completed map is presented as one flat vector with a valid/ready handshake, so the next map can be written while the current one is consumed. Frame-boundary errors are detected via an end-of-map marker.

---
 rtl/npu_buf_pkg.sv | 21 ++
 rtl/input_fmap_buffer_fmap_bank.sv | 56 +++++
 rtl/input_fmap_buffer.sv | 103 ++++++++++
 tb/tb_input_fmap_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_buf_pkg.sv
// Shared definitions for the NPU input/weight buffers.
// Holds the AXI word width and the size derivations so that every buffer
// computes map and word counts the same way.
package npu_buf_pkg;

  localparam int AXI_DATA_W = 32;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int map_elems(input int channels, input int height, input int width);
    return channels * height * width;
  endfunction

  // Number of AXI words needed to carry one map.
  function automatic int map_words(input int elems, input int pack);
    return ceil_div(elems, pack);
  endfunction

endpackage

// File: rtl/input_fmap_buffer_fmap_bank.sv
// fmap_bank: one bank of the ping-pong feature-map buffer.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears data and full)
//   i_wr_en         write one AXI word into the bank
//   i_wr_idx        word index; the word fills elements idx*PACK .. idx*PACK+PACK-1
//   i_wr_data       packed elements, element j at [j*DATA_W +: DATA_W]
//   i_set_full      mark the bank as holding a complete map
//   i_clr_full      release the bank after it has been read
//   o_data          flat map, element k at [k*DATA_W +: DATA_W]
//   o_full          bank holds a complete, unread map
module fmap_bank
  import npu_buf_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int PACK      = 1,
  parameter int MAP_ELEMS = 81,
  parameter int IDX_W     = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_wr_en,
  input  logic [IDX_W-1:0]            i_wr_idx,
  input  logic [AXI_DATA_W-1:0]       i_wr_data,
  input  logic                        i_set_full,
  input  logic                        i_clr_full,
  output logic [MAP_ELEMS*DATA_W-1:0] o_data,
  output logic                        o_full
);

  logic [MAP_ELEMS*DATA_W-1:0] r_data;
  logic                        r_full;

  // Each element checks whether the current word covers it. Elements past
  // MAP_ELEMS simply have no storage, which discards the tail of the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_wr_en) begin
        for (int k = 0; k < MAP_ELEMS; k++) begin
          if (int'(i_wr_idx) == k / PACK)
            r_data[k*DATA_W +: DATA_W] <= DATA_W'(i_wr_data >> ((k % PACK) * DATA_W));
        end
      end
      if (i_set_full)
        r_full <= 1'b1;
      else if (i_clr_full)
        r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/input_fmap_buffer.sv
// input_fmap_buffer: double-buffered feature-map buffer between the AXI write
// path and the preprocessing unit. Words are unpacked into the write bank; a
// completed map is offered as one flat vector while the other bank fills.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   write word stream, s_last marks final word
//   m_fmap/m_valid/m_ready          completed map, element k at [k*DATA_W +: DATA_W]
//   frame_err       one-cycle pulse when s_last disagrees with the word count
//   fill_words      words written so far into the current write bank
module input_fmap_buffer
  import npu_buf_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int IN_W     = 9,
  parameter int IN_H     = 9,
  parameter int CHANNELS = 1,
  parameter int PACK     = 1
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [AXI_DATA_W-1:0]                                 s_data,
  input  logic                                                  s_valid,
  input  logic                                                  s_last,
  output logic                                                  s_ready,
  output logic [DATA_W*map_elems(CHANNELS, IN_H, IN_W)-1:0]     m_fmap,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic                                                  frame_err,
  output logic [$clog2(map_words(map_elems(CHANNELS, IN_H, IN_W), PACK)+1)-1:0] fill_words
);

  localparam int MAP_ELEMS = map_elems(CHANNELS, IN_H, IN_W);
  localparam int WORDS     = map_words(MAP_ELEMS, PACK);
  localparam int FILL_W    = $clog2(WORDS + 1);
  localparam int MAP_BITS  = MAP_ELEMS * DATA_W;
  localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(WORDS - 1);

  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [FILL_W-1:0] r_fill;
  logic              r_frame_err;

  logic [1:0]          w_full;
  logic [MAP_BITS-1:0] w_bank_data [2];
  logic                w_accept;
  logic                w_last_word;
  logic                w_commit;
  logic                w_early;
  logic                w_rd_hs;

  assign s_ready     = !w_full[r_wr_sel];
  assign m_valid     = w_full[r_rd_sel];
  assign w_accept    = s_valid && s_ready;
  assign w_last_word = (r_fill == LAST_IDX);
  assign w_commit    = w_accept && w_last_word;
  assign w_early     = w_accept && s_last && !w_last_word;
  assign w_rd_hs     = m_valid && m_ready;

  // A bank can never be set and cleared in the same cycle: setting requires
  // it empty (write side), clearing requires it full (read side).
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(
      .DATA_W   (DATA_W),
      .PACK     (PACK),
      .MAP_ELEMS(MAP_ELEMS),
      .IDX_W    (FILL_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_accept && !w_early && (r_wr_sel == 1'(b))),
      .i_wr_idx  (r_fill),
      .i_wr_data (s_data),
      .i_set_full(w_commit && (r_wr_sel == 1'(b))),
      .i_clr_full(w_rd_hs && (r_rd_sel == 1'(b))),
      .o_data    (w_bank_data[b]),
      .o_full    (w_full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_fill      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (w_commit && !s_last) || w_early;
      if (w_commit || w_early)
        r_fill <= '0;
      else if (w_accept)
        r_fill <= r_fill + 1'b1;
      if (w_commit)
        r_wr_sel <= !r_wr_sel;
      if (w_rd_hs)
        r_rd_sel <= !r_rd_sel;
    end
  end

  assign m_fmap     = r_rd_sel ? w_bank_data[1] : w_bank_data[0];
  assign frame_err  = r_frame_err;
  assign fill_words = r_fill;

endmodule

// File: tb/tb_input_fmap_buffer.sv
module tb_input_fmap_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [323:0] m_fmap;
  logic         m_valid;
  logic         m_ready;
  logic         frame_err;
  logic [6:0]   fill_words;

  logic         p_reset;
  logic [31:0]  p_s_data;
  logic         p_s_valid;
  logic         p_s_last;
  logic         p_s_ready;
  logic [323:0] p_m_fmap;
  logic         p_m_valid;
  logic         p_m_ready;
  logic         p_frame_err;
  logic [3:0]   p_fill;

  int checks   = 0;
  int failures = 0;
  int stalls;
  int ferr_seen;

  always #5 clk = ~clk;

  input_fmap_buffer dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_fmap(m_fmap), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .fill_words(fill_words)
  );

  input_fmap_buffer #(.DATA_W(4), .IN_W(9), .IN_H(9), .CHANNELS(1), .PACK(8)) dut_p8 (
    .clk(clk), .reset(p_reset), .s_data(p_s_data), .s_valid(p_s_valid), .s_last(p_s_last),
    .s_ready(p_s_ready), .m_fmap(p_m_fmap), .m_valid(p_m_valid), .m_ready(p_m_ready),
    .frame_err(p_frame_err), .fill_words(p_fill)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Map whose element k holds (k + off) mod 16.
  function automatic logic [511:0] exp_map(input int off);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 81; k++) r[k*4 +: 4] = 4'((k + off) % 16);
    return r;
  endfunction

  // PACK=8 map of repeated 0x76543210 words; element 80 comes from the last word.
  function automatic logic [511:0] exp_p8(input logic [3:0] last_elem);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 80; k++) r[k*4 +: 4] = 4'(k % 8);
    r[80*4 +: 4] = last_elem;
    return r;
  endfunction

  // Words start..stop-1 with data = index + off; s_last on index last_at.
  task automatic send_words(input int off, input int start, input int stop, input int last_at);
    for (int i = start; i < stop; i++) begin
      if (!s_ready) stalls++;
      s_valid = 1'b1;
      s_data  = 32'(i + off);
      s_last  = (i == last_at);
      step();
      if (frame_err) ferr_seen++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    step();
    reset   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    p_reset = 1'b1; p_s_data = '0; p_s_valid = 1'b0; p_s_last = 1'b0; p_m_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    chk("rst_s_ready", 512'(s_ready), 512'(1));
    chk("rst_m_valid", 512'(m_valid), 512'(0));
    chk("rst_frame_err", 512'(frame_err), 512'(0));
    chk("rst_fill", 512'(fill_words), 512'(0));

    // Map 1, values 0..80, consumer idle.
    stalls = 0; ferr_seen = 0;
    send_words(0, 0, 41, -1);
    chk("m1_fill41", 512'(fill_words), 512'(41));
    send_words(0, 41, 80, -1);
    chk("m1_valid_before_last", 512'(m_valid), 512'(0));
    send_words(0, 80, 81, 80);
    chk("m1_valid", 512'(m_valid), 512'(1));
    chk("m1_data", 512'(m_fmap), exp_map(0));
    chk("m1_s_ready", 512'(s_ready), 512'(1));
    chk("m1_fill0", 512'(fill_words), 512'(0));
    chk("m1_no_stall_no_err", 512'(stalls + ferr_seen), 512'(0));

    // Ping-pong stall: second map fills bank 1, third must wait.
    send_words(5, 0, 81, 80);
    chk("m2_no_stall", 512'(stalls), 512'(0));
    chk("m2_s_ready_low", 512'(s_ready), 512'(0));
    chk("m2_hold_m1", 512'(m_fmap), exp_map(0));
    s_valid = 1'b1; s_data = 32'd9; s_last = 1'b0;
    step();
    chk("stall_not_accepted", 512'(fill_words), 512'(0));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; s_valid = 1'b0;
    chk("pp_m2_valid", 512'(m_valid), 512'(1));
    chk("pp_m2_data", 512'(m_fmap), exp_map(5));
    chk("pp_s_ready_back", 512'(s_ready), 512'(1));
    chk("pp_fill_still0", 512'(fill_words), 512'(0));
    stalls = 0;
    send_words(9, 0, 81, 80);
    chk("m3_no_stall", 512'(stalls), 512'(0));
    chk("m3_both_full", 512'(s_ready), 512'(0));
    m_ready = 1'b1;
    step();
    chk("m3_data", 512'(m_fmap), exp_map(9));
    chk("m3_valid", 512'(m_valid), 512'(1));
    step();
    m_ready = 1'b0;
    chk("drained_valid", 512'(m_valid), 512'(0));
    chk("drained_s_ready", 512'(s_ready), 512'(1));

    // Early s_last on word 40, then a clean map.
    send_words(2, 0, 41, 40);
    chk("early_err", 512'(frame_err), 512'(1));
    chk("early_fill0", 512'(fill_words), 512'(0));
    chk("early_no_valid", 512'(m_valid), 512'(0));
    step();
    chk("early_err_1cyc", 512'(frame_err), 512'(0));
    ferr_seen = 0;
    send_words(7, 0, 81, 80);
    chk("clean_no_err", 512'(ferr_seen), 512'(0));
    chk("clean_valid", 512'(m_valid), 512'(1));
    chk("clean_data", 512'(m_fmap), exp_map(7));
    m_ready = 1'b1; step(); m_ready = 1'b0;

    // Missing s_last on word 80.
    send_words(11, 0, 81, -1);
    chk("nolast_err", 512'(frame_err), 512'(1));
    chk("nolast_valid", 512'(m_valid), 512'(1));
    chk("nolast_data", 512'(m_fmap), exp_map(11));
    step();
    chk("nolast_err_1cyc", 512'(frame_err), 512'(0));
    m_ready = 1'b1; step(); m_ready = 1'b0;

    // Consumer keeping up: two maps back to back, no write stalls.
    stalls = 0;
    m_ready = 1'b1;
    send_words(1, 0, 81, 80);
    chk("tp_m1_valid", 512'(m_valid), 512'(1));
    chk("tp_m1_data", 512'(m_fmap), exp_map(1));
    send_words(4, 0, 1, -1);
    chk("tp_read_done", 512'(m_valid), 512'(0));
    send_words(4, 1, 81, 80);
    chk("tp_no_stall", 512'(stalls), 512'(0));
    chk("tp_m2_data", 512'(m_fmap), exp_map(4));
    // Commit into one bank while the other is read in the same cycle.
    m_ready = 1'b0;
    send_words(6, 0, 80, -1);
    m_ready = 1'b1;
    send_words(6, 80, 81, 80);
    m_ready = 1'b0;
    chk("sim_valid", 512'(m_valid), 512'(1));
    chk("sim_data", 512'(m_fmap), exp_map(6));
    chk("sim_s_ready", 512'(s_ready), 512'(1));

    // Reset mid-map, and with one bank full.
    send_words(3, 0, 50, -1);
    pulse_reset();
    chk("rst_mid_valid", 512'(m_valid), 512'(0));
    chk("rst_mid_s_ready", 512'(s_ready), 512'(1));
    chk("rst_mid_fill", 512'(fill_words), 512'(0));
    send_words(8, 0, 81, 80);
    send_words(8, 0, 10, -1);
    pulse_reset();
    chk("rst_full_valid", 512'(m_valid), 512'(0));
    chk("rst_full_s_ready", 512'(s_ready), 512'(1));
    chk("rst_full_fill", 512'(fill_words), 512'(0));
    ferr_seen = 0;
    send_words(13, 0, 81, 80);
    chk("post_rst_valid", 512'(m_valid), 512'(1));
    chk("post_rst_data", 512'(m_fmap), exp_map(13));
    chk("post_rst_no_err", 512'(ferr_seen), 512'(0));

    // PACK=8: 11 words per map, only element 0 of word 10 kept.
    p_reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      p_s_valid = 1'b1;
      p_s_data  = (i == 10) ? 32'h7654_3210 : 32'h7654_3210;
      p_s_last  = (i == 10);
      step();
      if (i == 4) chk("p8_fill5", 512'(p_fill), 512'(5));
    end
    p_s_valid = 1'b0; p_s_last = 1'b0;
    chk("p8_valid", 512'(p_m_valid), 512'(1));
    chk("p8_err", 512'(p_frame_err), 512'(0));
    chk("p8_elem80", 512'(p_m_fmap[80*4 +: 4]), 512'(0));
    chk("p8_elem7", 512'(p_m_fmap[7*4 +: 4]), 512'(7));
    chk("p8_data", 512'(p_m_fmap), exp_p8(4'h0));
    p_m_ready = 1'b1; step(); p_m_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      p_s_valid = 1'b1;
      p_s_data  = (i == 10) ? 32'hFFFF_FFF5 : 32'h7654_3210;
      p_s_last  = (i == 10);
      step();
    end
    p_s_valid = 1'b0; p_s_last = 1'b0;
    chk("p8_tail_valid", 512'(p_m_valid), 512'(1));
    chk("p8_tail_data", 512'(p_m_fmap), exp_p8(4'h5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
